// File: rtl/crc5_pkg.sv
// crc5_pkg: shared definitions for the USB token CRC5 checker and generator.
//   - crc5_state_e : checker FSM states
//   - CRC5_SEED / CRC5_RESIDUE : LFSR preset and good-packet residual
//   - TOKEN_FIELD_BITS / CRC5_BITS : token field and CRC lengths
//   - crc5_next() : one serial LFSR step, polynomial x^5+x^2+1
package crc5_pkg;

   typedef enum logic [1:0] {IDLE, FIELD, CRC, DONE} crc5_state_e;

   localparam logic [4:0] CRC5_SEED        = 5'b11111;
   localparam logic [4:0] CRC5_RESIDUE     = 5'b01100;
   localparam int         TOKEN_FIELD_BITS = 11;
   localparam int         CRC5_BITS        = 5;

   // fb = r[4]^b; r0<=fb, r1<=r0, r2<=r1^fb, r3<=r2, r4<=r3
   function automatic logic [4:0] crc5_next(input logic [4:0] r, input logic b);
      logic fb;
      fb = r[4] ^ b;
      return {r[3], r[2], r[1] ^ fb, r[0], fb};
   endfunction

endpackage

// File: rtl/crc5_lfsr.sv
// crc5_lfsr: serial CRC5 register, shared by the receive checker and the
// transmit generator.
//   clk, rst : clock, synchronous active-high reset (register <= SEED)
//   load_i   : preset the register to SEED (wins over en_i)
//   en_i     : advance one step with bit_i
//   bit_i    : serial data bit
//   r_o      : current register contents r[4:0]
module crc5_lfsr
   import crc5_pkg::*;
#(
   parameter logic [4:0] SEED = CRC5_SEED
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [4:0] r_o
);

   logic [4:0] r_q, r_d;

   always_comb begin
      r_d = r_q;
      if (load_i)    r_d = SEED;
      else if (en_i) r_d = crc5_next(r_q, bit_i);
   end

   always_ff @(posedge clk) begin
      if (rst) r_q <= SEED;
      else     r_q <= r_d;
   end

   assign r_o = r_q;

endmodule

// File: rtl/crc5_check.sv
// crc5_check: receive-side CRC5 checker for USB token packets.
// Takes the 16 post-PID bits serially (11-bit ADDR/ENDP LSB-first, then
// 5 CRC bits), checks the LFSR residual and reports a one-cycle result.
//   clk, rst    : clock, synchronous active-high reset
//   chk_start   : seed the LFSR and arm (accepted in IDLE or DONE only)
//   s_in        : unstuffed data bit, qualified by s_valid
//   s_valid     : s_in valid this cycle (gaps allowed)
//   pkt_end     : EOP; aborts the packet if fewer than 16 bits arrived
//   busy        : packet in progress (FIELD, CRC, DONE)
//   token_field : captured field, bit 0 first received
//   chk_done    : one-cycle completion pulse
//   crc_ok / crc_err / len_err : result flags, qualified by chk_done
module crc5_check
   import crc5_pkg::*;
#(
   parameter logic [4:0] SEED    = CRC5_SEED,
   parameter logic [4:0] RESIDUE = CRC5_RESIDUE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        chk_start,
   input  logic                        s_in,
   input  logic                        s_valid,
   input  logic                        pkt_end,
   output logic                        busy,
   output logic [TOKEN_FIELD_BITS-1:0] token_field,
   output logic                        chk_done,
   output logic                        crc_ok,
   output logic                        crc_err,
   output logic                        len_err
);

   localparam logic [3:0] FIELD_LAST = 4'(TOKEN_FIELD_BITS - 1);
   localparam logic [3:0] CRC_LAST   = 4'(CRC5_BITS - 1);

   crc5_state_e                 state_q, state_d;
   logic [3:0]                  cnt_q, cnt_d;
   logic [TOKEN_FIELD_BITS-1:0] field_q, field_d;
   logic                        busy_q, done_q, ok_q, err_q, len_q;

   logic       accept, start_ok;
   logic       fin, fin_ok, fin_len;
   logic [4:0] r;
   logic [4:0] r_adv;

   assign accept   = s_valid && (state_q == FIELD || state_q == CRC);
   assign start_ok = chk_start && (state_q == IDLE || state_q == DONE);
   // Register value after the bit being accepted this cycle; the result is
   // judged on it so chk_done can register in the same edge as the last bit.
   assign r_adv    = crc5_next(r, s_in);

   crc5_lfsr #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load_i(start_ok),
      .en_i  (accept),
      .bit_i (s_in),
      .r_o   (r)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      field_d = field_q;
      fin     = 1'b0;
      fin_ok  = 1'b0;
      fin_len = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = FIELD;
               cnt_d   = '0;
               field_d = '0;
            end
         end
         FIELD: begin
            if (accept) begin
               for (int i = 0; i < TOKEN_FIELD_BITS; i++)
                  if (cnt_q == 4'(i)) field_d[i] = s_in;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == FIELD_LAST) begin
                  state_d = CRC;
                  cnt_d   = '0;
               end
            end
            // Any EOP here is short, whether or not a bit came with it.
            if (pkt_end) begin
               state_d = DONE;
               cnt_d   = '0;
               fin     = 1'b1;
               fin_len = 1'b1;
            end
         end
         CRC: begin
            if (accept) cnt_d = cnt_q + 4'd1;
            // 16th bit completes normally even if EOP arrives with it.
            if (accept && cnt_q == CRC_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               fin     = 1'b1;
               fin_ok  = (r_adv == RESIDUE);
            end else if (pkt_end) begin
               state_d = DONE;
               cnt_d   = '0;
               fin     = 1'b1;
               fin_len = 1'b1;
            end
         end
         DONE: begin
            if (start_ok) begin
               state_d = FIELD;
               cnt_d   = '0;
               field_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         field_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         len_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         field_q <= field_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= fin;
         ok_q    <= fin & fin_ok;
         err_q   <= fin & ~fin_ok;
         len_q   <= fin & fin_len;
      end
   end

   assign busy        = busy_q;
   assign token_field = field_q;
   assign chk_done    = done_q;
   assign crc_ok      = ok_q;
   assign crc_err     = err_q;
   assign len_err     = len_q;

endmodule

// File: tb/tb_crc5_check.sv
// tb_crc5_check: directed self-checking bench for crc5_check.
// Packets are 16-bit vectors, bit i = i-th bit on the wire.
module tb_crc5_check;

   logic        clk = 1'b0;
   logic        rst, chk_start, s_in, s_valid, pkt_end;
   logic        busy, chk_done, crc_ok, crc_err, len_err;
   logic [10:0] token_field;

   int tests = 0;
   int fails = 0;

   // All-zero field, CRC bits 0,1,0,0,0 -> residual 01100
   localparam logic [15:0] GOOD = 16'h1000;
   // Same with field bit 4 flipped
   localparam logic [15:0] BAD  = 16'h1010;

   crc5_check dut (
      .clk        (clk),
      .rst        (rst),
      .chk_start  (chk_start),
      .s_in       (s_in),
      .s_valid    (s_valid),
      .pkt_end    (pkt_end),
      .busy       (busy),
      .token_field(token_field),
      .chk_done   (chk_done),
      .crc_ok     (crc_ok),
      .crc_err    (crc_err),
      .len_err    (len_err)
   );

   always #5 clk = ~clk;

   // Apply inputs for one cycle; return 1ns after the edge that sampled them.
   task automatic drive(input logic st, input logic v, input logic b, input logic e);
      chk_start = st; s_valid = v; s_in = b; pkt_end = e;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests++; if (chk_done !== 1'b0 || crc_ok !== 1'b0 || crc_err !== 1'b0 || len_err !== 1'b0) begin
         fails++; $display("FAIL rst_flags: got done=%b ok=%b err=%b len=%b want 0000", chk_done, crc_ok, crc_err, len_err); end
      tests++; if (token_field !== 11'h000) begin fails++; $display("FAIL rst_field: got %h want 000", token_field); end
      tests++; if (dut.u_lfsr.r_q !== 5'b11111) begin fails++; $display("FAIL rst_lfsr: got %b want 11111", dut.u_lfsr.r_q); end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_good;
      int early = 0;
      // s_valid with a 1 in the start cycle must be dropped
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL good_busy: got %b want 1", busy); end
      for (int i = 0; i < 16; i++) begin
         // EOP together with the 16th bit is a normal completion
         drive(1'b0, 1'b1, GOOD[i], (i == 15));
         if (i < 15 && chk_done) early++;
         if (i == 10) begin
            tests++; if (dut.u_lfsr.r_q !== 5'b10111) begin fails++; $display("FAIL good_r_after_field: got %b want 10111", dut.u_lfsr.r_q); end
         end
      end
      tests++; if (early != 0) begin fails++; $display("FAIL good_early_done: got %0d early pulses want 0", early); end
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b1 || crc_err !== 1'b0 || len_err !== 1'b0) begin
         fails++; $display("FAIL good_result: got done=%b ok=%b err=%b len=%b want 1100", chk_done, crc_ok, crc_err, len_err); end
      tests++; if (token_field !== 11'h000) begin fails++; $display("FAIL good_field: got %h want 000", token_field); end
      // s_valid in DONE is ignored
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tests++; if (chk_done !== 1'b0 || crc_ok !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL good_after: got done=%b ok=%b busy=%b want 000", chk_done, crc_ok, busy); end
      tests++; if (token_field !== 11'h000) begin fails++; $display("FAIL good_field_hold: got %h want 000", token_field); end
   endtask

   task automatic test_bad;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, BAD[i], 1'b0);
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b0 || crc_err !== 1'b1 || len_err !== 1'b0) begin
         fails++; $display("FAIL bad_result: got done=%b ok=%b err=%b len=%b want 1010", chk_done, crc_ok, crc_err, len_err); end
      tests++; if (token_field !== 11'h010) begin fails++; $display("FAIL bad_field: got %h want 010", token_field); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_gaps;
      int early = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0);  // hole with junk on s_in
         if (chk_done) early++;
         drive(1'b0, 1'b1, GOOD[i], 1'b0);
         if (i < 15 && chk_done) early++;
      end
      tests++; if (early != 0) begin fails++; $display("FAIL gaps_early_done: got %0d want 0", early); end
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b1 || crc_err !== 1'b0) begin
         fails++; $display("FAIL gaps_result: got done=%b ok=%b err=%b want 110", chk_done, crc_ok, crc_err); end
      tests++; if (token_field !== 11'h000) begin fails++; $display("FAIL gaps_field: got %h want 000", token_field); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_short;
      logic [8:0] bits = 9'b1_0100_1101;  // 0x14D, bit 0 sent first
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, bits[i], 1'b0);
      tests++; if (chk_done !== 1'b0) begin fails++; $display("FAIL short_pre: got done=%b want 0", chk_done); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b0 || crc_err !== 1'b1 || len_err !== 1'b1) begin
         fails++; $display("FAIL short_result: got done=%b ok=%b err=%b len=%b want 1011", chk_done, crc_ok, crc_err, len_err); end
      tests++; if (token_field !== 11'h14D) begin fails++; $display("FAIL short_field: got %h want 14d", token_field); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_end_with_bit;
      // 15th bit arrives together with EOP: accepted, then aborted as short
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b1, (i == 14));
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b0 || crc_err !== 1'b1 || len_err !== 1'b1) begin
         fails++; $display("FAIL end15_result: got done=%b ok=%b err=%b len=%b want 1011", chk_done, crc_ok, crc_err, len_err); end
      tests++; if (token_field !== 11'h7FF) begin fails++; $display("FAIL end15_field: got %h want 7ff", token_field); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      int pulses = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, GOOD[i], 1'b0);
      pulses += int'(chk_done);
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b1) begin
         fails++; $display("FAIL b2b_first: got done=%b ok=%b want 11", chk_done, crc_ok); end
      // chk_start in DONE re-arms; the valid bit alongside it is dropped
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      tests++; if (busy !== 1'b1 || chk_done !== 1'b0) begin
         fails++; $display("FAIL b2b_rearm: got busy=%b done=%b want 10", busy, chk_done); end
      for (int i = 0; i < 16; i++) begin
         drive((i == 5), 1'b1, BAD[i], 1'b0);  // mid-packet start ignored
         if (i < 15) pulses += int'(chk_done);
      end
      pulses += int'(chk_done);
      tests++; if (chk_done !== 1'b1 || crc_err !== 1'b1 || crc_ok !== 1'b0) begin
         fails++; $display("FAIL b2b_second: got done=%b err=%b ok=%b want 110", chk_done, crc_err, crc_ok); end
      tests++; if (token_field !== 11'h010) begin fails++; $display("FAIL b2b_field: got %h want 010", token_field); end
      tests++; if (pulses != 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid;
      int stray = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      tests++; if (busy !== 1'b0 || token_field !== 11'h000) begin
         fails++; $display("FAIL rmid_cleared: got busy=%b field=%h want 0 000", busy, token_field); end
      // remaining bits of the dead packet must not complete anything
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, 1'b0, (i == 11));
         stray += int'(chk_done);
      end
      tests++; if (stray != 0) begin fails++; $display("FAIL rmid_stray_done: got %0d want 0", stray); end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, GOOD[i], 1'b0);
      tests++; if (chk_done !== 1'b1 || crc_ok !== 1'b1 || len_err !== 1'b0) begin
         fails++; $display("FAIL rmid_fresh: got done=%b ok=%b len=%b want 110", chk_done, crc_ok, len_err); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; chk_start = 1'b0; s_in = 1'b0; s_valid = 1'b0; pkt_end = 1'b0;
      test_reset();
      test_good();
      test_bad();
      test_gaps();
      test_short();
      test_end_with_bit();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
